// File: rtl/updown_counter_reg.sv
`default_nettype none
// ============================================================================
// Module  : updown_counter_reg
// Brief   : WIDTH-bit loadable up/down counter with programmable modulus,
//           wrap/saturate bound handling, terminal count and sticky overflow.
// Revision: 1.0 - initial release
// ============================================================================
module updown_counter_reg #(
  parameter int          WIDTH     = 4,
  parameter int unsigned MAX_VAL   = (2**WIDTH)-1,
  parameter int unsigned RESET_VAL = 0,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_n,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] C_MAX   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] C_RESET = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] C_ZERO  = '0;
  localparam logic [WIDTH-1:0] C_ONE   = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_count_n;
  logic             r_ovf;

  logic             w_at_max;
  logic             w_at_zero;
  logic             w_hit_bound;
  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] w_count_nxt;

  assign w_at_max       = (r_count == C_MAX);
  assign w_at_zero      = (r_count == C_ZERO);
  assign w_hit_bound    = en & ~load & (up ? w_at_max : w_at_zero);
  assign w_load_clamped = (load_val > C_MAX) ? C_MAX : load_val;

  always_comb begin
    w_count_nxt = r_count;
    if (load) begin
      w_count_nxt = w_load_clamped;
    end else if (en) begin
      if (up) begin
        if (!w_at_max) begin
          w_count_nxt = r_count + C_ONE;
        end else if (!SATURATE) begin
          w_count_nxt = C_ZERO;
        end
      end else begin
        if (!w_at_zero) begin
          w_count_nxt = r_count - C_ONE;
        end else if (!SATURATE) begin
          w_count_nxt = C_MAX;
        end
      end
    end
  end

  // The complement is kept as its own register so count_n is glitch-free
  // and never needs an inverter on the output path.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count   <= C_RESET;
      r_count_n <= ~C_RESET;
      r_ovf     <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      r_count_n <= ~w_count_nxt;
      if (w_hit_bound) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign count   = r_count;
  assign count_n = r_count_n;
  assign tc      = w_hit_bound;
  assign ovf     = r_ovf;

endmodule
`default_nettype wire
